// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in serial-out transmitter, valid/ready on both sides,
//            with first/last framing flags on the serial beat.
// Revision : 1.0
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_first,
    output logic             so_last,
    output logic             busy
);

    localparam int                c_CW    = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_ZERO  = '0;
    localparam logic [c_CW-1:0]   c_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0]   c_LAST  = c_CW'(WIDTH - 1);

    localparam logic [0:0]        c_IDLE  = 1'b0;
    localparam logic [0:0]        c_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sh;
    logic [c_CW-1:0]  r_cnt;

    logic             w_active;
    logic             w_beat;
    logic             w_load;
    logic             w_last;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;

    // Shift direction only changes which end is the output and which end fills.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_sh[WIDTH-1];
            assign w_shifted = {r_sh[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_sh[0];
            assign w_shifted = {1'b0, r_sh[WIDTH-1:1]};
        end
    endgenerate

    assign w_active = (r_state == c_SHIFT);
    assign w_last   = w_active && (r_cnt == c_LAST);
    assign w_beat   = w_active && so_ready;

    // Ready is gated by rst so that no load can be signalled during reset.
    assign pi_ready = rst && (!w_active || (w_beat && w_last));
    assign w_load   = pi_valid && pi_ready;

    assign so       = w_active && w_out_bit;
    assign so_valid = w_active;
    assign so_first = w_active && (r_cnt == c_ZERO);
    assign so_last  = w_last;
    assign busy     = w_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_sh    <= '0;
            r_cnt   <= c_ZERO;
        end else if (w_load) begin
            r_state <= c_SHIFT;
            r_sh    <= pi;
            r_cnt   <= c_ZERO;
        end else if (w_beat) begin
            if (w_last) begin
                r_state <= c_IDLE;
                r_sh    <= '0;
                r_cnt   <= c_ZERO;
            end else begin
                r_sh    <= w_shifted;
                r_cnt   <= r_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Vector table, directed corner sequences and random handshakes
//            against a word/beat-index reference model for three instances.
// Revision : 1.0
// ============================================================================
module tb_piso_serializer;

    typedef struct {
        logic [3:0] pi;
        logic       pv;
        logic       sr;
        logic [5:0] exp;   // {so_valid, so(msb dut), so(lsb dut), so_first, so_last, pi_ready}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pi;
    logic       pi_valid;
    logic       so_ready;

    logic [2:0] pi_ready_o, so_o, so_valid_o, so_first_o, so_last_o, busy_o;

    int   n_cmp = 0;
    int   n_err = 0;

    int   mw [3] = '{4, 4, 2};
    bit   mmsb [3] = '{1'b1, 1'b0, 1'b1};
    bit   m_act [3];
    int   m_idx [3];
    logic [3:0] m_word [3];

    vec_t tbl [$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready_o[0]),
        .so(so_o[0]), .so_valid(so_valid_o[0]), .so_ready(so_ready),
        .so_first(so_first_o[0]), .so_last(so_last_o[0]), .busy(busy_o[0]));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready_o[1]),
        .so(so_o[1]), .so_valid(so_valid_o[1]), .so_ready(so_ready),
        .so_first(so_first_o[1]), .so_last(so_last_o[1]), .busy(busy_o[1]));

    piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_w2 (
        .clk(clk), .rst(rst), .pi(pi[1:0]), .pi_valid(pi_valid), .pi_ready(pi_ready_o[2]),
        .so(so_o[2]), .so_valid(so_valid_o[2]), .so_ready(so_ready),
        .so_first(so_first_o[2]), .so_last(so_last_o[2]), .busy(busy_o[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_so(input int i);
        int k;
        if (!m_act[i]) return 1'b0;
        k = mmsb[i] ? (mw[i] - 1 - m_idx[i]) : m_idx[i];
        return m_word[i][k];
    endfunction

    function automatic logic exp_ready(input int i);
        return rst && (!m_act[i] || (so_ready && m_idx[i] == mw[i] - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0;
            m_idx[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit beat, rdy;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_act[i] = 1'b0;
                m_idx[i] = 0;
            end else begin
                beat = m_act[i] && so_ready;
                rdy  = !m_act[i] || (beat && m_idx[i] == mw[i] - 1);
                if (pi_valid && rdy) begin
                    m_word[i] = (mw[i] == 2) ? {2'b00, pi[1:0]} : pi;
                    m_idx[i]  = 0;
                    m_act[i]  = 1'b1;
                end else if (beat) begin
                    if (m_idx[i] == mw[i] - 1) begin
                        m_act[i] = 1'b0;
                        m_idx[i] = 0;
                    end else begin
                        m_idx[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("so[%0d]", i),       32'(so_o[i]),       32'(exp_so(i)));
            chk($sformatf("so_valid[%0d]", i), 32'(so_valid_o[i]), 32'(m_act[i]));
            chk($sformatf("busy[%0d]", i),     32'(busy_o[i]),     32'(m_act[i]));
            chk($sformatf("so_first[%0d]", i), 32'(so_first_o[i]), 32'(m_act[i] && m_idx[i] == 0));
            chk($sformatf("so_last[%0d]", i),  32'(so_last_o[i]),  32'(m_act[i] && m_idx[i] == mw[i] - 1));
            chk($sformatf("pi_ready[%0d]", i), 32'(pi_ready_o[i]), 32'(exp_ready(i)));
        end
    endtask

    // Drive inputs just after an edge and check mid-cycle.
    task automatic drive(input logic [3:0] p, input logic v, input logic r);
        pi       = p;
        pi_valid = v;
        so_ready = r;
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [3:0] p, input logic v, input logic r);
        drive(p, v, r);
        tick();
    endtask

    initial begin
        int         n;
        logic [7:0] seq;

        // Basic MSB/LSB transfer of 1011
        tbl.push_back('{4'b1011, 1'b1, 1'b1, 6'b000001});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b111100});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b101000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b110000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b111011});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b000001});
        // Word 0001: MSB-first 0,0,0,1 / LSB-first 1,0,0,0
        tbl.push_back('{4'b0001, 1'b1, 1'b1, 6'b000001});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b101100});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b100000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b100000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b110011});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b000001});
        // Back-to-back 1111 then 1001 with pi_valid held
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 6'b000001});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 6'b111100});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 6'b111000});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 6'b111000});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 6'b111011});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b111100});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b100000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b100000});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b111011});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 6'b000001});

        rst = 1'b0; pi = '0; pi_valid = 1'b0; so_ready = 1'b0;
        model_reset();
        #2;
        check_all();
        #10;
        rst = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pi, tbl[i].pv, tbl[i].sr);
            chk($sformatf("tbl%0d.valid", i), 32'(so_valid_o[0]), 32'(tbl[i].exp[5]));
            chk($sformatf("tbl%0d.so_m", i),  32'(so_o[0]),       32'(tbl[i].exp[4]));
            chk($sformatf("tbl%0d.so_l", i),  32'(so_o[1]),       32'(tbl[i].exp[3]));
            chk($sformatf("tbl%0d.first", i), 32'(so_first_o[0]), 32'(tbl[i].exp[2]));
            chk($sformatf("tbl%0d.last", i),  32'(so_last_o[0]),  32'(tbl[i].exp[1]));
            chk($sformatf("tbl%0d.ready", i), 32'(pi_ready_o[0]), 32'(tbl[i].exp[0]));
            tick();
        end

        // Consumer stall of 3 cycles during beat 1 of 0101
        step(4'b0101, 1'b1, 1'b1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            drive(4'b0000, 1'b0, (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
            if (so_valid_o[0]) n++;
            if (c >= 1 && c <= 3) begin
                chk("stall.so", 32'(so_o[0]), 32'd1);
                chk("stall.valid", 32'(so_valid_o[0]), 32'd1);
            end
            tick();
        end
        chk("stall.word_cycles", 32'(n), 32'd7);

        // Producer offering 1111 while 0001 is still shifting
        step(4'b0001, 1'b1, 1'b1);
        seq = '0;
        for (int c = 0; c < 8; c++) begin
            drive((c >= 1 && c <= 3) ? 4'b1111 : 4'b0000, (c >= 1 && c <= 3), 1'b1);
            if (c == 1) chk("busy.pi_ready", 32'(pi_ready_o[0]), 32'd0);
            seq = {seq[6:0], so_o[0]};
            tick();
        end
        chk("busy.sequence", 32'(seq), 32'h1F);
        step(4'b0000, 1'b0, 1'b1);

        // Asynchronous reset at beat 2 of 1011, then a clean 0101
        step(4'b1011, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst.so_valid", 32'(so_valid_o[0]), 32'd0);
        chk("rst.so_last", 32'(so_last_o[0]), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        step(4'b0101, 1'b1, 1'b1);
        seq = '0;
        for (int c = 0; c < 4; c++) begin
            drive(4'b0000, 1'b0, 1'b1);
            if (c == 0) chk("rst.first", 32'(so_first_o[0]), 32'd1);
            seq = {seq[6:0], so_o[0]};
            tick();
        end
        chk("rst.sequence", 32'(seq), 32'h05);

        // Random handshakes on all three instances
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom_range(0, 15)), ($urandom % 4) != 0, ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter with valid/ready handshakes on both sides. It accepts one WIDTH-bit word from a parallel producer and shifts it out one bit per accepted beat, with first/last framing flags. It is the serial-launch counterpart to the team's parallel register stages and the transmit end of the parallel/serial link used by the shift-register family.

## Interface
- WIDTH, default 4: word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- pi  input  WIDTH  parallel word to transmit.
- pi_valid  input  1  producer offers pi this cycle.
- pi_ready  output  1  block can accept pi this cycle (combinational).
- so  output  1  current serial bit.
- so_valid  output  1  so holds a valid beat.
- so_ready  input  1  consumer accepts the beat this cycle.
- so_first  output  1  current beat is bit 0 of the word in shift order.
- so_last  output  1  current beat is the final bit of the word.
- busy  output  1  a word is being shifted out; equals so_valid.

## Operation
- State machine has two states:
  - IDLE: no word held.
  - SHIFT: word held in shift register sh[WIDTH-1:0]; beat counter cnt counts 0..WIDTH-1 and is $clog2(WIDTH) bits wide.
- Load handshake: a load happens on a rising edge where pi_valid && pi_ready. The load writes pi into sh, sets cnt=0, and sets state=SHIFT.
- pi_ready = rst && ((state==IDLE) || (so_valid && so_ready && so_last)).
  - pi_ready is 0 while rst is low.
  - pi_ready is 0 during SHIFT except in the cycle where the final beat is accepted.
- Outputs in SHIFT:
  - so = sh[WIDTH-1] when MSB_FIRST=1, else sh[0].
  - so_valid = 1.
  - so_first = (cnt==0).
  - so_last = (cnt==WIDTH-1).
- Beat handshake: a beat is accepted on a rising edge where so_valid && so_ready.
  - For a non-last beat: sh shifts toward the output end, the vacated bit fills with 0, and cnt increments.
  - For a last beat with a simultaneous load: sh=pi, cnt=0, state stays SHIFT. There is no bubble between words.
  - For a last beat without a load: state=IDLE and cnt=0.
- Stall: when so_ready=0, so, so_first, so_last, sh and cnt all hold.
- In IDLE: so=0, so_valid=0, so_first=0, so_last=0.
- pi_valid while pi_ready=0 is ignored. The word is not captured and is not queued; the producer must hold it.
- Changes to pi after a load do not affect the word already being shifted.

## Timing
- Reset (rst low, asynchronous): state=IDLE, sh=0, cnt=0, so=0, so_valid=0, so_first=0, so_last=0, busy=0, pi_ready=0.
- First rising edge after rst returns high: pi_ready=1.
- Latency: a word loaded at edge N drives its first bit on so during cycle N+1, with so_valid=1 and so_first=1.
- Throughput with so_ready held at 1: WIDTH beats per word. Consecutive words are contiguous when pi_valid is held.
- With so_ready=1 and no new word, the last beat is in cycle N+WIDTH and so_valid is 0 from cycle N+WIDTH+1.
- Reset asserted mid-word: the word is dropped. Outputs go to their reset values immediately, with no partial completion. The next word starts again at so_first.
- WIDTH=2 corner case: so_first and so_last are mutually exclusive, and cnt is 1 bit wide.

## Test plan
- Basic MSB-first transfer:
  - Stimulus: WIDTH=4, MSB_FIRST=1, so_ready=1, single load of pi=4'b1011.
  - Required: so = 1,0,1,1 on 4 consecutive cycles; so_first on beat 0 only; so_last on beat 3 only; so_valid=0 afterwards; pi_ready=1 in IDLE.
- LSB-first transfer:
  - Stimulus: MSB_FIRST=0, load pi=4'b0001.
  - Required: so = 1,0,0,0.
- Back-to-back words:
  - Stimulus: pi_valid held with 4'b1111 then 4'b1001.
  - Required: 8 contiguous valid beats 1,1,1,1,1,0,0,1; pi_ready pulses only on the last beat of the first word; so_first on beats 0 and 4.
- Consumer stall:
  - Stimulus: load 4'b0101, then drop so_ready for 3 cycles during beat 1.
  - Required: so holds 1 with so_valid=1 throughout the stall; the sequence 0,1,0,1 completes intact; total word time is 7 cycles.
- Producer while busy:
  - Stimulus: pi_valid=1 with pi=4'b1111 during beat 1 of word 4'b0001.
  - Required: pi_ready=0 and word 4'b0001 is unaffected. 4'b1111 is accepted only on the last beat.
- Reset mid-word:
  - Stimulus: drive rst low between clock edges at beat 2 of 4'b1011.
  - Required: so_valid, so, so_first and so_last drop to 0 immediately. After release, a fresh load of 4'b0101 shifts out cleanly starting at so_first.
